// File: rtl/rand_stream_src.sv
// ============================================================================
// rand_stream_src : packetised incrementing-data stream source with
//                   LFSR-driven idle gaps and ready backpressure.
// Revision        : 1.0
// ============================================================================
`default_nettype none

module rand_stream_src #(
  parameter int          LEN     = 8,
  parameter int          PKT_LEN = 4,
  parameter int          GAP_W   = 3,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           enable,
  input  logic           rand_en,
  input  logic           ready_in,
  output logic           valid_out,
  output logic [LEN-1:0] data_out,
  output logic           last_out,
  output logic [15:0]    pkt_count,
  output logic           busy
);

  localparam int                  c_BEAT_W    = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(PKT_LEN - 1);
  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [15:0]         c_LFSR_INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [LEN-1:0]      r_seq;
  logic [c_BEAT_W-1:0] r_beat;
  logic [15:0]         r_lfsr;
  logic [GAP_W-1:0]    r_gap_cnt;
  logic [15:0]         r_pkt_count;

  logic                w_xfer;
  logic                w_is_last;
  logic                w_lfsr_fb;
  logic [GAP_W-1:0]    w_gap;

  assign w_xfer    = (r_state == S_SEND) && ready_in;
  assign w_is_last = (r_beat == c_LAST_BEAT);
  // Gap length comes from the LFSR value before this transfer's step.
  assign w_gap     = rand_en ? r_lfsr[GAP_W-1:0] : '0;
  // Fibonacci taps for x^16+x^14+x^13+x^11+1 in right-shift form.
  assign w_lfsr_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    valid_out   = 1'b0;
    busy        = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (enable) begin
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        valid_out = 1'b1;
        if (w_xfer) begin
          if (w_is_last && !enable) begin
            w_state_nxt = S_IDLE;
          end else if (w_gap != '0) begin
            w_state_nxt = S_GAP;
          end else begin
            w_state_nxt = S_SEND;
          end
        end
      end
      S_GAP: begin
        if (r_gap_cnt <= GAP_W'(1)) begin
          w_state_nxt = S_SEND;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        busy        = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_seq       <= '0;
      r_beat      <= '0;
      r_lfsr      <= c_LFSR_INIT;
      r_gap_cnt   <= '0;
      r_pkt_count <= '0;
    end else if (w_xfer) begin
      r_seq     <= r_seq + LEN'(1);
      r_lfsr    <= {w_lfsr_fb, r_lfsr[15:1]};
      r_gap_cnt <= w_gap;
      if (w_is_last) begin
        r_beat      <= '0;
        r_pkt_count <= r_pkt_count + 16'd1;
      end else begin
        r_beat <= r_beat + c_BEAT_W'(1);
      end
    end else if (r_state == S_GAP) begin
      r_gap_cnt <= r_gap_cnt - GAP_W'(1);
    end
  end

  assign data_out  = r_seq;
  assign last_out  = valid_out && w_is_last;
  assign pkt_count = r_pkt_count;

endmodule

`default_nettype wire

// File: tb/tb_rand_stream_src.sv
// ============================================================================
// tb_rand_stream_src : scoreboard bench for rand_stream_src.
// Revision           : 1.0
// ============================================================================
`default_nettype none

module tb_rand_stream_src;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, enable, rand_en, ready_in;
  logic        valid_out, last_out, busy;
  logic [7:0]  data_out;
  logic [15:0] pkt_count;

  logic        en1, ready1;
  logic        valid1, last1, busy1;
  logic [3:0]  data1;
  logic [15:0] pkt1;

  rand_stream_src #(.LEN(8), .PKT_LEN(4), .GAP_W(3), .SEED(16'hACE1)) u_dut (
    .clk(clk), .rst(rst), .enable(enable), .rand_en(rand_en), .ready_in(ready_in),
    .valid_out(valid_out), .data_out(data_out), .last_out(last_out),
    .pkt_count(pkt_count), .busy(busy)
  );

  rand_stream_src #(.LEN(4), .PKT_LEN(1), .GAP_W(3), .SEED(16'hACE1)) u_dut1 (
    .clk(clk), .rst(rst), .enable(en1), .rand_en(1'b0), .ready_in(ready1),
    .valid_out(valid1), .data_out(data1), .last_out(last1),
    .pkt_count(pkt1), .busy(busy1)
  );

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         gap;   // idle cycles expected before this beat; -1 = unchecked
  } beat_t;

  beat_t q[$];
  beat_t q1[$];
  beat_t e, e1;

  int n_pass = 0;
  int n_total = 0;
  int xfer_cnt = 0;
  int xfer1 = 0;
  int idle = 0;
  int max_gap = 0;
  int stall_cnt = 0;
  bit prev_stall = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail(input string msg);
    n_total++;
    $display("FAIL %s", msg);
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  task automatic push(input int d, input bit l, input int g);
    beat_t b;
    b.data = d[7:0];
    b.last = l;
    b.gap  = g;
    q.push_back(b);
  endtask

  // Expected beats of a random-gap run starting from a freshly reset LFSR.
  task automatic push_random(input int n);
    logic [15:0] s;
    int prev_g;
    s = 16'hACE1;
    prev_g = -1;
    for (int i = 0; i < n; i++) begin
      push(i, (i % 4) == 3, prev_g);
      prev_g = int'(s[2:0]);
      s = lfsr_step(s);
    end
  endtask

  task automatic wait_xfers(input int target);
    int cyc;
    cyc = 0;
    while (xfer_cnt < target && cyc < 2000) begin
      @(posedge clk);
      cyc++;
    end
    if (xfer_cnt < target) chk("xfer_timeout", xfer_cnt, target);
    #1;
  endtask

  task automatic wait_xfers1(input int target);
    int cyc;
    cyc = 0;
    while (xfer1 < target && cyc < 2000) begin
      @(posedge clk);
      cyc++;
    end
    if (xfer1 < target) chk("xfer1_timeout", xfer1, target);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    enable = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_valid", valid_out, 0);
    chk("rst_last", last_out, 0);
    chk("rst_data", data_out, 0);
    chk("rst_pkt_count", pkt_count, 0);
    chk("rst_busy", busy, 0);
    q.delete();
    rst = 1'b0;
  endtask

  // Monitor for the LEN=8/PKT_LEN=4 instance.
  always @(negedge clk) begin
    if (rst) begin
      idle = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) chk("valid_dropped_without_xfer", valid_out, 1);
      if (!valid_out) begin
        idle++;
        chk("last_while_invalid", last_out, 0);
      end else if (q.size() == 0) begin
        fail($sformatf("unexpected_beat: data %0h with empty expectation queue", data_out));
      end else if (!ready_in) begin
        stall_cnt++;
        chk("stall_hold_data", data_out, q[0].data);
        chk("stall_hold_last", last_out, q[0].last);
      end else begin
        e = q.pop_front();
        chk("beat_data", data_out, e.data);
        chk("beat_last", last_out, e.last);
        if (e.gap >= 0) begin
          chk("gap_len", idle, e.gap);
          if (idle > max_gap) max_gap = idle;
        end
        xfer_cnt++;
        idle = 0;
      end
      prev_stall = valid_out && !ready_in;
    end
  end

  // Monitor for the LEN=4/PKT_LEN=1 instance.
  always @(negedge clk) begin
    if (!rst) begin
      if (!valid1) begin
        chk("u1_last_while_invalid", last1, 0);
      end else if (ready1) begin
        if (q1.size() == 0) begin
          fail($sformatf("u1_unexpected_beat: data %0h with empty expectation queue", data1));
        end else begin
          e1 = q1.pop_front();
          chk("u1_beat_data", data1, e1.data);
          chk("u1_beat_last", last1, e1.last);
        end
        xfer1++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int base;
    int sbase;
    beat_t b;
    rst = 1'b1; enable = 1'b0; rand_en = 1'b0; ready_in = 1'b1;
    en1 = 1'b0; ready1 = 1'b1;

    // Back-to-back stream, two packets.
    do_reset();
    rand_en = 1'b0; ready_in = 1'b1;
    for (int i = 0; i < 8; i++) push(i, (i % 4) == 3, (i == 0) ? -1 : 0);
    base = xfer_cnt;
    enable = 1'b1;
    chk("start_latency_pre", valid_out, 0);
    @(posedge clk); #1;
    chk("start_latency_post", valid_out, 1);
    chk("busy_in_send", busy, 1);
    wait_xfers(base + 5);
    enable = 1'b0;
    wait_xfers(base + 8);
    chk("b2b_pkt_count", pkt_count, 2);
    chk("b2b_idle_valid", valid_out, 0);
    chk("b2b_idle_busy", busy, 0);
    chk("b2b_drain", q.size(), 0);

    // Backpressure on data 2 for five cycles.
    do_reset();
    for (int i = 0; i < 8; i++) push(i, (i % 4) == 3, (i == 0) ? -1 : 0);
    base = xfer_cnt;
    sbase = stall_cnt;
    enable = 1'b1;
    wait_xfers(base + 2);
    ready_in = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    ready_in = 1'b1;
    chk("bp_stall_cycles", stall_cnt - sbase, 5);
    wait_xfers(base + 5);
    enable = 1'b0;
    wait_xfers(base + 8);
    chk("bp_pkt_count", pkt_count, 2);
    chk("bp_drain", q.size(), 0);

    // Random gaps, 32 transfers.
    do_reset();
    rand_en = 1'b1; ready_in = 1'b1;
    push_random(32);
    base = xfer_cnt;
    max_gap = 0;
    enable = 1'b1;
    wait_xfers(base + 29);
    enable = 1'b0;
    wait_xfers(base + 32);
    chk("rand_pkt_count", pkt_count, 8);
    chk("rand_idle_valid", valid_out, 0);
    chk("rand_max_gap_le7", (max_gap <= 7), 1);
    chk("rand_drain", q.size(), 0);

    // Enable dropped after beat 1.
    do_reset();
    rand_en = 1'b0; ready_in = 1'b1;
    for (int i = 0; i < 4; i++) push(i, i == 3, (i == 0) ? -1 : 0);
    base = xfer_cnt;
    enable = 1'b1;
    wait_xfers(base + 2);
    enable = 1'b0;
    wait_xfers(base + 4);
    chk("drop_valid", valid_out, 0);
    chk("drop_busy", busy, 0);
    chk("drop_pkt_count", pkt_count, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("drop_stays_idle", valid_out, 0);
    chk("drop_drain", q.size(), 0);
    for (int i = 4; i < 8; i++) push(i, i == 7, (i == 4) ? -1 : 0);
    enable = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
    chk("resume_valid", valid_out, 1);
    chk("resume_data", data_out, 4);
    wait_xfers(base + 8);
    chk("resume_pkt_count", pkt_count, 2);
    chk("resume_drain", q.size(), 0);

    // Reset mid-packet, then the gap sequence must repeat from the start.
    do_reset();
    rand_en = 1'b1; ready_in = 1'b1;
    push_random(3);
    base = xfer_cnt;
    enable = 1'b1;
    wait_xfers(base + 2);
    ready_in = 1'b0;
    for (int c = 0; c < 100 && !valid_out; c++) begin
      @(posedge clk); #1;
    end
    chk("midrst_beat2_valid", valid_out, 1);
    chk("midrst_beat2_data", data_out, 2);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_valid", valid_out, 0);
    chk("midrst_pkt_count", pkt_count, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_data", data_out, 0);
    q.delete();
    rst = 1'b0;
    ready_in = 1'b1;
    push_random(32);
    base = xfer_cnt;
    wait_xfers(base + 29);
    enable = 1'b0;
    wait_xfers(base + 32);
    chk("midrst_rerun_pkt_count", pkt_count, 8);
    chk("midrst_rerun_drain", q.size(), 0);

    // LEN=4, PKT_LEN=1: sequence wrap with last on every beat.
    for (int i = 0; i < 20; i++) begin
      b.data = 8'(i % 16);
      b.last = 1'b1;
      b.gap  = -1;
      q1.push_back(b);
    end
    base = xfer1;
    ready1 = 1'b1;
    en1 = 1'b1;
    wait_xfers1(base + 19);
    en1 = 1'b0;
    wait_xfers1(base + 20);
    chk("wrap_pkt_count", pkt1, 20);
    chk("wrap_idle_valid", valid1, 0);
    chk("wrap_drain", q1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
